// File: rtl/inject_sched.sv
// inject_sched: walks NSRC one-shot dataout buffers in turn, funnelling each burst
// through a 4-deep FIFO onto the router injection link with gap, timeout and error tracking.
module inject_sched #(
    parameter int NSRC      = 4,
    parameter int DW        = 20,
    parameter int BURST_LEN = 30,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic [NSRC-1:0]      src_en,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*DW-1:0]   src_data,
    output logic [DW-1:0]        link_data,
    output logic                 link_valid,
    input  logic                 link_ready,
    output logic [2:0]           cur_src,
    output logic                 busy,
    output logic                 all_done,
    output logic [NSRC+1:0]      err_flags
);
    localparam int FDEPTH = 4;
    localparam int WW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(BURST_LEN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    G_LAST = 4'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
    localparam logic [2:0]    S_LAST = 3'(NSRC - 1);

    typedef enum logic [2:0] {IDLE, BURST, GAP, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [DW-1:0]   mem [FDEPTH];
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      count;
    logic [WW-1:0]   wcnt;
    logic [TW-1:0]   tcnt;
    logic [3:0]      gcnt;
    logic            en_q;
    logic [NSRC-1:0] sel;
    logic            active, word, full, pop, push, stray, tout, last_word;

    always_comb begin
        sel        = NSRC'(1) << cur_src;
        active     = state == BURST || state == GAP;
        word       = active && |(src_valid & sel);
        full       = count == 3'(FDEPTH);
        link_valid = count != '0;
        link_data  = link_valid ? mem[rd_ptr] : '0;
        pop        = link_valid && link_ready;
        push       = word && (!full || pop);
        stray      = |(src_valid & (active ? ~sel : {NSRC{1'b1}}));
        tout       = state == BURST && !word && tcnt == T_LAST;
        last_word  = state == BURST && word && wcnt == W_LAST;
        // en_q accounts for the word already requested but not yet landed
        src_en     = (state == BURST && (count + {2'b0, en_q}) < 3'(FDEPTH)) ? sel : '0;
        busy       = state == BURST || state == GAP || state == DRAIN;
        all_done   = state == DONE;
        state_nx   = state;
        unique case (state)
            IDLE:    state_nx = go ? BURST : IDLE;
            BURST:   state_nx = (last_word || tout) ? GAP : BURST;
            GAP:     state_nx = gcnt != G_LAST ? GAP : (cur_src == S_LAST ? DRAIN : BURST);
            DRAIN:   state_nx = count == '0 ? DONE : DRAIN;
            DONE:    state_nx = go ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= src_data[cur_src*DW +: DW];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wcnt      <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
            en_q      <= 1'b0;
            cur_src   <= '0;
            err_flags <= '0;
        end else begin
            state     <= state_nx;
            en_q      <= |src_en;
            wr_ptr    <= wr_ptr + 2'(push);
            rd_ptr    <= rd_ptr + 2'(pop);
            count     <= count + 3'(push) - 3'(pop);
            gcnt      <= state == GAP ? gcnt + 4'd1 : '0;
            err_flags <= (state == IDLE && go) ? '0
                       : err_flags | {stray, word && !push, {NSRC{tout}} & sel};
            if (state != BURST && state_nx == BURST) begin
                cur_src <= state == GAP ? cur_src + 3'd1 : '0;
                wcnt    <= '0;
                tcnt    <= '0;
            end else begin
                if (word) wcnt <= wcnt + WW'(1);
                if (state == BURST) tcnt <= word ? '0 : tcnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_inject_sched.sv
// tb_inject_sched: random-data bursts from modelled one-shot buffers, link stream
// compared against the source-ordered concatenation of every non-silent burst.
module tb_inject_sched;
    localparam int NSRC = 4, DW = 20, BL = 30;

    logic clk = 0, rst = 0, go = 0, link_ready = 1, sel = 0;
    logic [NSRC-1:0]    src_valid = '0;
    logic [NSRC*DW-1:0] src_data = '0;
    logic [NSRC-1:0]    en_a, en_b, src_en_o;
    logic [DW-1:0]      ld_a, ld_b, ld;
    logic               lv_a, lv_b, lv, bz_a, bz_b, bz, dn_a, dn_b, dn;
    logic [2:0]         cs_a, cs_b, cs;
    logic [NSRC+1:0]    er_a, er_b, er;

    // the idle instance is held in reset so only the selected one reacts
    inject_sched dut_a (.clk(clk), .rst(sel ? 1'b0 : rst), .go(go), .src_en(en_a),
        .src_valid(src_valid), .src_data(src_data), .link_data(ld_a), .link_valid(lv_a),
        .link_ready(link_ready), .cur_src(cs_a), .busy(bz_a), .all_done(dn_a), .err_flags(er_a));
    inject_sched #(.GAP_CYC(0)) dut_b (.clk(clk), .rst(sel ? rst : 1'b0), .go(go), .src_en(en_b),
        .src_valid(src_valid), .src_data(src_data), .link_data(ld_b), .link_valid(lv_b),
        .link_ready(link_ready), .cur_src(cs_b), .busy(bz_b), .all_done(dn_b), .err_flags(er_b));

    assign src_en_o = sel ? en_b : en_a;
    assign ld = sel ? ld_b : ld_a;
    assign lv = sel ? lv_b : lv_a;
    assign bz = sel ? bz_b : bz_a;
    assign dn = sel ? dn_b : dn_a;
    assign cs = sel ? cs_b : cs_a;
    assign er = sel ? er_b : er_a;

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [DW-1:0] words [NSRC][BL];
    int ptr [NSRC];
    logic [DW-1:0] got[$], exp_q[$];
    logic [NSRC-1:0] silent;
    logic [DW-1:0] hold;
    int cyc = 0, idle_en, en2_cyc, sc, stall_bad, stall_left, stall_src, ready_mode = 0;
    bit stalled, strayed, stray_on, have_hold, done_seen;

    task automatic prep(input logic [NSRC-1:0] sil, input int ssrc, input bit str);
        silent = sil; stall_src = ssrc; stray_on = str;
        stalled = 0; strayed = 0; have_hold = 0; done_seen = 0;
        sc = 0; stall_bad = 0; stall_left = 0; idle_en = 0; en2_cyc = 0;
        got.delete(); exp_q.delete();
        for (int k = 0; k < NSRC; k++) begin
            ptr[k] = 0;
            for (int i = 0; i < BL; i++) begin
                words[k][i] = DW'($urandom);
                if (!sil[k]) exp_q.push_back(words[k][i]);
            end
        end
    endtask

    task automatic reset_dut();
        rst = 0; go = 0; src_valid = '0; src_data = '0; link_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    // one clock: observe link and enables, then act as the buffers for the next cycle
    task automatic step();
        logic [NSRC-1:0] en;
        en = src_en_o;
        if (lv && link_ready) got.push_back(ld);
        if (bz && en == '0) idle_en++;
        if (en[2]) en2_cyc++;
        if (dn) done_seen = 1;
        if (!link_ready && ready_mode == 0) begin
            sc++;
            if (lv) begin
                if (!have_hold) begin hold = ld; have_hold = 1; end
                else if (ld !== hold) stall_bad++;
            end
            if (sc > 10 && (en != '0 || !lv)) stall_bad++;
        end
        @(posedge clk);
        #1 cyc++;
        src_valid = '0; src_data = '0;
        for (int k = 0; k < NSRC; k++)
            if (en[k] && ptr[k] < BL && !silent[k]) begin
                src_valid[k] = 1'b1;
                src_data[k*DW +: DW] = words[k][ptr[k]];
                ptr[k]++;
            end
        if (stray_on && !strayed && cs == 3'd0 && ptr[0] >= 5) begin
            strayed = 1; src_valid[3] = 1'b1; src_data[3*DW +: DW] = DW'($urandom);
        end
        if (!stalled && stall_src >= 0 && int'(cs) == stall_src && ptr[stall_src] >= 10) begin
            stalled = 1; stall_left = 20;
        end
        if (stall_left > 0) begin link_ready = 0; stall_left--; end
        else link_ready = ready_mode != 0 ? cyc[0] : 1'b1;
    endtask

    task automatic run();
        go = 1;
        for (int i = 0; i < 3000 && !done_seen; i++) step();
        go = 0;
        step(); step();
    endtask

    task automatic check_stream(input string name, input logic [NSRC+1:0] err_exp);
        int bad;
        tests++;
        if (!done_seen) begin fails++; $display("FAIL %s_done all_done never seen within budget", name); end
        tests++;
        if (got.size() != exp_q.size()) begin
            fails++; $display("FAIL %s_count got %0d words want %0d", name, got.size(), exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (bad < 0 && got[i] !== exp_q[i]) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++; $display("FAIL %s_order word %0d got %h want %h", name, bad, got[bad], exp_q[bad]);
        end
        tests++;
        if (er !== err_exp) begin fails++; $display("FAIL %s_err got %b want %b", name, er, err_exp); end
    endtask

    task automatic test_reset();
        reset_dut();
        tests++; if (src_en_o !== '0) begin fails++; $display("FAIL rst_src_en got %b want 0", src_en_o); end
        tests++; if (lv !== 1'b0) begin fails++; $display("FAIL rst_link_valid got %b want 0", lv); end
        tests++; if (ld !== '0) begin fails++; $display("FAIL rst_link_data got %h want 0", ld); end
        tests++; if (cs !== 3'd0) begin fails++; $display("FAIL rst_cur_src got %0d want 0", cs); end
        tests++; if (bz !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bz); end
        tests++; if (dn !== 1'b0) begin fails++; $display("FAIL rst_all_done got %b want 0", dn); end
        tests++; if (er !== '0) begin fails++; $display("FAIL rst_err got %b want 0", er); end
    endtask

    task automatic test_full_run();
        reset_dut(); ready_mode = 0; prep('0, -1, 0); run();
        check_stream("full", '0);
        // each of NSRC gaps lasts GAP_CYC cycles, plus one DRAIN cycle
        tests++;
        if (idle_en != NSRC * 2 + 1) begin fails++; $display("FAIL full_gap_cycles got %0d want %0d", idle_en, NSRC * 2 + 1); end
    endtask

    task automatic test_backpressure();
        reset_dut(); ready_mode = 0; prep('0, 1, 0); run();
        check_stream("stall", '0);
        tests++;
        if (!stalled || sc != 20 || stall_bad != 0) begin
            fails++; $display("FAIL stall_hold stalled=%0d cycles=%0d violations=%0d want 1/20/0", stalled, sc, stall_bad);
        end
    endtask

    task automatic test_timeout();
        reset_dut(); ready_mode = 0; prep(4'b0100, -1, 0); run();
        check_stream("timeout", 6'b000100);
        tests++;
        if (en2_cyc != 64) begin fails++; $display("FAIL timeout_len got %0d enabled cycles want 64", en2_cyc); end
    endtask

    task automatic test_stray();
        reset_dut(); ready_mode = 0; prep('0, -1, 1); run();
        tests++; if (!strayed) begin fails++; $display("FAIL stray_inject got 0 want 1"); end
        check_stream("stray", 6'b100000);
    endtask

    task automatic test_mid_reset();
        reset_dut(); ready_mode = 0; prep('0, -1, 0);
        go = 1;
        for (int i = 0; i < 1000 && !(cs == 3'd2 && ptr[2] >= 5); i++) step();
        tests++; if (cs !== 3'd2) begin fails++; $display("FAIL mreset_reach cur_src got %0d want 2", cs); end
        rst = 0; go = 0; src_valid = '0; src_data = '0;
        @(posedge clk);
        #1;
        tests++;
        if (src_en_o !== '0 || lv !== 1'b0 || ld !== '0 || cs !== 3'd0 || bz !== 1'b0 || dn !== 1'b0 || er !== '0) begin
            fails++;
            $display("FAIL mreset_outputs got en=%b lv=%b ld=%h cs=%0d busy=%b done=%b err=%b want all 0",
                     src_en_o, lv, ld, cs, bz, dn, er);
        end
        rst = 1;
    endtask

    task automatic test_gap0_toggle();
        sel = 1; reset_dut(); ready_mode = 1; prep('0, -1, 0); run();
        check_stream("gap0", '0);
        tests++; if (er[NSRC] !== 1'b0) begin fails++; $display("FAIL gap0_overflow got %b want 0", er[NSRC]); end
        ready_mode = 0; sel = 0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_timeout();
        test_stray();
        test_mid_reset();
        test_gap0_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inject_sched.md
INJECT_SCHED -- requirements
Module: inject_sched

Interface
REQ-001 Parameter NSRC, default 4, number of dataout buffers sequenced (2..8).
REQ-002 Parameter DW, default 20, flit width.
REQ-003 Parameter BURST_LEN, default 30, words expected per source burst.
REQ-004 Parameter GAP_CYC, default 2, idle cycles between bursts (0..15).
REQ-005 Parameter TIMEOUT, default 64, consecutive word-less BURST cycles before a source is skipped.
REQ-006 Parameter FDEPTH, fixed 4, internal FIFO depth.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 go  in  1  level start request; sampled in IDLE.
REQ-010 src_en  out  NSRC  one-hot (or zero) enable to the dataout buffers.
REQ-011 src_valid  in  NSRC  per-source word-valid (out_valid of each buffer).
REQ-012 src_data  in  NSRC*DW  flat source data; source k at bits [k*DW +: DW].
REQ-013 link_data  out  DW  FIFO head word to the router injection port.
REQ-014 link_valid  out  1  FIFO non-empty.
REQ-015 link_ready  in  1  router accepts link_data this cycle.
REQ-016 cur_src  out  3  index of source currently served.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 all_done  out  1  high in DONE.
REQ-019 err_flags  out  NSRC+2  sticky: [NSRC-1:0] per-source timeout, [NSRC] FIFO overflow, [NSRC+1] stray valid.

Function
REQ-020 States IDLE, BURST, GAP, DRAIN, DONE shall be implemented; IDLE on reset.
REQ-021 IDLE -> BURST with cur_src=0, word counter=0, timeout counter=0 on go=1.
REQ-022 In BURST, src_en[cur_src] = (fifo_count + en_q) < FDEPTH, where en_q is src_en[cur_src] from the previous cycle; all other src_en bits 0; src_en all 0 outside BURST.
REQ-023 A word from cur_src (src_valid[cur_src]=1 in BURST or GAP) shall be pushed into the FIFO and increment the word counter.
REQ-024 BURST -> GAP on the cycle the BURST_LEN-th word is pushed.
REQ-025 The timeout counter shall increment each BURST cycle without a cur_src word, clear on a word; reaching TIMEOUT sets err_flags[cur_src] and forces BURST -> GAP.
REQ-026 GAP shall last exactly GAP_CYC cycles (GAP_CYC=0: one cycle), then -> BURST with cur_src+1 and counters cleared, or -> DRAIN if cur_src=NSRC-1.
REQ-027 DRAIN -> DONE when FIFO empty; DONE -> IDLE when go=0.
REQ-028 link_valid = fifo_count != 0; pop when link_valid && link_ready; link_data stable while link_valid && !link_ready.
REQ-029 Push and pop in the same cycle are both honoured, including at fifo_count=FDEPTH; count unchanged.
REQ-030 Push with FIFO full and no pop shall drop the word and set err_flags[NSRC].
REQ-031 src_valid on any source other than cur_src, or any src_valid in IDLE/DRAIN/DONE, shall be ignored and set err_flags[NSRC+1].
REQ-032 err_flags clear only on reset or on IDLE -> BURST.
REQ-033 Word order on the link shall equal push order; no word duplicated.

Reset
REQ-034 On rst=0 at a clock edge: state IDLE, src_en=0, link_valid=0, link_data=0, cur_src=0, busy=0, all_done=0, err_flags=0, FIFO empty, all counters 0.
REQ-035 Reset mid-burst shall discard FIFO contents; re-arming the one-shot buffers is the system's responsibility.

Verification
REQ-036 NSRC=4, BURST_LEN=30, link_ready=1, go=1 -> 120 words on link in source order 0..3, all_done=1, err_flags=0.
REQ-037 link_ready=0 for 20 cycles mid-burst 1 -> fifo_count peaks at 4, src_en[1] low while full, no word lost, err_flags=0.
REQ-038 Source 2 silent -> after 64 cycles err_flags[2]=1, source 3 served next, 90 words total.
REQ-039 Pulse src_valid[3] during burst 0 -> err_flags[5]=1, word not on link.
REQ-040 rst=0 for one cycle during burst 2 -> next cycle all outputs at REQ-034 values, link_valid=0.
REQ-041 GAP_CYC=0, link_ready toggling 1/0 -> push+pop at full occurs, order preserved, no overflow flag.
